noc_input_vc_buffer: RTL
========================

Name: noc_input_vc_buffer

Overview:
- Input-port stage of a router; directly downstream of the flit link. It acts as the receiver side of Noc_flit_interface.
- Holds one FIFO per virtual channel and produces per-VC ready and vc_ready back to the upstream sender.
- Tracks packet framing per VC.
- Presents each VC's head flit, with its header/tail flags, to route computation and the switch allocator.

Parameters:
- CHANNEL, Noc_VC_Channel, number of virtual channels.
- DATA_WIDTH, Noc_Data_Width, flit width in bits.
- PORT_TYPE, INTERNAL, port_type of the link. Non-INTERNAL means a single shared flit lane.
- FLIT_NUM, (PORT_TYPE) ? 1 : CHANNEL, number of input flit lanes.
- BUF_DEPTH, Noc_VC_Buf_Depth (4), entries per VC FIFO. Must be a power of two, ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  CHANNEL  per-VC flit valid from upstream. At most one bit set when FLIT_NUM==1.
- in_ready  output  CHANNEL  per-VC FIFO-not-full.
- in_flit  input  FLIT_NUM x DATA_WIDTH  flit lanes, unpacked array.
- in_is_header  input  FLIT_NUM  header flag per lane.
- in_is_tail  input  FLIT_NUM  tail flag per lane.
- vc_ready  output  CHANNEL  VC free for allocation by a new packet.
- out_valid  output  CHANNEL  VC FIFO non-empty.
- out_ready  input  CHANNEL  downstream pops the VC head this cycle.
- out_flit  output  CHANNEL x DATA_WIDTH  head flit per VC.
- out_is_header  output  CHANNEL  head flit header flag.
- out_is_tail  output  CHANNEL  head flit tail flag.
- err  output  CHANNEL  sticky framing error (see Optional Feature).

Behaviour:
- Reset (async, rst=1), outputs:
  - in_ready = all 1s.
  - vc_ready = all 1s.
  - out_valid = 0, err = 0.
  - out_flit and header/tail flags = 0.
  - All pointers and counters cleared; every VC state = IDLE.
- Reset mid-packet discards all buffered flits. No outputs glitch after deassert.
- Lane select:
  - VC v reads lane v when FLIT_NUM==CHANNEL, else lane 0.
  - With FLIT_NUM==1, two or more in_valid bits set is a framing error; all pushes that cycle are dropped.
- Push: in_valid[v] && in_ready[v] at a clk edge writes {is_header, is_tail, flit} into FIFO v.
- in_ready[v]:
  - Equals (count[v] != BUF_DEPTH), registered-state based.
  - When full, a same-cycle pop does NOT enable a push. There is no combinational path from out_ready to in_ready.
- Pop: out_valid[v] && out_ready[v] advances the head. out_ready while empty is ignored.
- Latency: a flit pushed at edge N is visible on out_valid/out_flit after edge N (1 cycle). There is no bypass.
- Simultaneous push+pop on a non-full, non-empty VC: count unchanged, both pointers advance.
- Pointers are log2(BUF_DEPTH) bits and wrap naturally. Count is log2(BUF_DEPTH)+1 bits.
- Per-VC framing FSM, driven by accepted pushes only:
  - IDLE --header & !tail--> BUSY.
  - IDLE --header & tail--> IDLE (single-flit packet).
  - BUSY --tail--> IDLE.
  - BUSY --body--> BUSY.
- Framing errors:
  - Non-header flit in IDLE: error.
  - Header in BUSY: error; the FSM restarts the packet (stays BUSY, or goes to IDLE if that flit is also a tail).
- vc_ready[v] = (state==IDLE) && (count==0) && !(push this cycle). It is registered, so it drops one cycle after the accepted header.
- VCs are fully independent; simultaneous pushes and pops on all VCs are legal.

Optional Feature:
- Macro: NOC_VC_BUF_ERR_CHECK_EN.
- Defined:
  - Framing errors and multi-valid (FLIT_NUM==1) set err[v], which stays set until reset.
  - The erroneous flit is still stored.
  - Simulation assertions fire on push-while-full attempts by the sender.
- Undefined:
  - err tied to 0.
  - Error detection logic and assertions removed.
  - FSM transitions otherwise identical.

Decomposition:
- Noc_parameters package: add Noc_VC_Buf_Depth (4) and typedef enum logic {VC_IDLE, VC_BUSY} vc_state_t.
- Sub-module noc_vc_fifo: single-VC FIFO with registered count, full/empty, DATA_WIDTH+2 payload. Instantiated CHANNEL times via generate.
- The top level holds lane select, framing FSMs and the err/vc_ready logic.

Test Plan:
Defaults are CHANNEL=4, BUF_DEPTH=4, PORT_TYPE=INTERNAL unless stated.
- Single-flit packet: push {hdr=1, tail=1, 0xA5} on VC2 → out_valid[2]=1 next cycle with flit 0xA5; vc_ready[2] drops for 1 cycle, then returns to 1 after the pop.
- Fill VC0: push 4 flits (hdr, body, body, tail), no pops → in_ready[0]=0 after the 4th. A 5th push attempt with out_ready[0]=1 the same cycle is rejected; in_ready[0]=1 on the following cycle.
- Simultaneous push/pop streaming: 16 flits through VC1 with out_ready held 1 → 16 flits out in order. Count stays ≤1 and pointers wrap 4 times.
- Interleaving: alternate VC0/VC3 packets of 3 flits each → each VC outputs only its own flits in order, and the FSMs end in IDLE.
- Framing error (ERR_CHECK_EN defined): body flit on IDLE VC1 → err[1]=1 next cycle and stays 1. Macro undefined → err stays 0.
- Reset mid-packet: 2 flits of a 4-flit packet in VC2, then assert rst → out_valid=0, in_ready=vc_ready=4'hF immediately (async). After release, a new header is accepted normally.

Source files
------------

// File: rtl/noc_input_vc_buffer_pkg.sv
// Shared parameters and types for the router input VC buffer.
package noc_input_vc_buffer_pkg;

  localparam int Noc_VC_Channel   = 4;
  localparam int Noc_Data_Width   = 32;
  localparam int Noc_VC_Buf_Depth = 4;

  // Link port types: INTERNAL links carry one flit lane per VC,
  // any other type shares a single lane across all VCs.
  localparam int INTERNAL = 0;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BUSY = 1'b1
  } vc_state_t;

  // Number of physical flit lanes on a link of the given type.
  function automatic int flit_lanes(input int port_type, input int channel);
    return (port_type != INTERNAL) ? 1 : channel;
  endfunction

endpackage

// File: rtl/noc_input_vc_buffer_if.sv
// Upstream flit link: per-VC valid, flit lanes with framing flags,
// and per-VC ready / vc_ready backpressure toward the sender.
interface noc_input_vc_buffer_if
  import noc_input_vc_buffer_pkg::*;
#(
  parameter int CHANNEL    = Noc_VC_Channel,
  parameter int DATA_WIDTH = Noc_Data_Width,
  parameter int FLIT_NUM   = Noc_VC_Channel
) ();

  logic [CHANNEL-1:0]    in_valid;
  logic [CHANNEL-1:0]    in_ready;
  logic [DATA_WIDTH-1:0] in_flit [FLIT_NUM];
  logic [FLIT_NUM-1:0]   in_is_header;
  logic [FLIT_NUM-1:0]   in_is_tail;
  logic [CHANNEL-1:0]    vc_ready;

  modport master (
    output in_valid, in_flit, in_is_header, in_is_tail,
    input  in_ready, vc_ready
  );

  modport slave (
    input  in_valid, in_flit, in_is_header, in_is_tail,
    output in_ready, vc_ready
  );

endinterface

// File: rtl/noc_input_vc_buffer_vc_fifo.sv
// Single-VC FIFO with registered occupancy count. Storage is not reset;
// the head output reads zero whenever the FIFO is empty.
module noc_vc_fifo #(
  parameter int WIDTH     = 34,
  parameter int BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come only from registered count, so a same-cycle pop
  // never opens room for a push.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and count update; pointers wrap naturally at BUF_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Router input port: one FIFO per virtual channel, per-VC packet framing
// tracking and vc_ready generation. Optional framing-error detection and
// push-while-full checks are enabled by defining NOC_VC_BUF_ERR_CHECK_EN.
module noc_input_vc_buffer
  import noc_input_vc_buffer_pkg::*;
#(
  parameter int CHANNEL    = Noc_VC_Channel,
  parameter int DATA_WIDTH = Noc_Data_Width,
  parameter int PORT_TYPE  = INTERNAL,
  parameter int FLIT_NUM   = flit_lanes(PORT_TYPE, CHANNEL),
  parameter int BUF_DEPTH  = Noc_VC_Buf_Depth
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_input_vc_buffer_if.slave  link,
  output logic [CHANNEL-1:0]    out_valid,
  input  logic [CHANNEL-1:0]    out_ready,
  output logic [DATA_WIDTH-1:0] out_flit [CHANNEL],
  output logic [CHANNEL-1:0]    out_is_header,
  output logic [CHANNEL-1:0]    out_is_tail,
  output logic [CHANNEL-1:0]    err
);

  logic [CHANNEL-1:0] full;
  logic [CHANNEL-1:0] empty;
  logic [CHANNEL-1:0] push;
  logic [CHANNEL-1:0] hdr_sel;
  logic [CHANNEL-1:0] tail_sel;
  logic [CHANNEL-1:0] vc_ready_q;
  logic               multi_valid;
  vc_state_t          state_q [CHANNEL];
  vc_state_t          state_d [CHANNEL];

  // On a shared lane, more than one valid in a cycle is ambiguous and
  // every push of that cycle is dropped.
  if (FLIT_NUM == 1) begin : g_shared_lane
    assign multi_valid = ($countones(link.in_valid) > 1);
  end else begin : g_per_vc_lane
    assign multi_valid = 1'b0;
  end

  for (genvar v = 0; v < CHANNEL; v++) begin : g_vc
    localparam int LANE = (FLIT_NUM == CHANNEL) ? v : 0;
    logic [DATA_WIDTH+1:0] wdata;
    logic [DATA_WIDTH+1:0] rdata;

    assign hdr_sel[v]  = link.in_is_header[LANE];
    assign tail_sel[v] = link.in_is_tail[LANE];
    assign push[v]     = link.in_valid[v] & ~full[v] & ~multi_valid;
    assign wdata       = {hdr_sel[v], tail_sel[v], link.in_flit[LANE]};

    noc_vc_fifo #(
      .WIDTH     (DATA_WIDTH + 2),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[v]),
      .wdata (wdata),
      .pop   (out_ready[v]),
      .rdata (rdata),
      .full  (full[v]),
      .empty (empty[v])
    );

    assign out_is_header[v] = rdata[DATA_WIDTH+1];
    assign out_is_tail[v]   = rdata[DATA_WIDTH];
    assign out_flit[v]      = rdata[DATA_WIDTH-1:0];
  end

  assign link.in_ready = ~full;
  assign link.vc_ready = vc_ready_q;
  assign out_valid     = ~empty;

  // Framing state register per VC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < CHANNEL; v++) state_q[v] <= VC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing next state from accepted pushes; a header always (re)starts a
  // packet, a tail always closes one.
  always_comb begin
    state_d = state_q;
    for (int v = 0; v < CHANNEL; v++) begin
      if (push[v]) begin
        if (hdr_sel[v])       state_d[v] = tail_sel[v] ? VC_IDLE : VC_BUSY;
        else if (tail_sel[v]) state_d[v] = VC_IDLE;
      end
    end
  end

  // VC is offered to a new packet only when idle, drained and not being
  // written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_ready_q <= '1;
    end else begin
      for (int v = 0; v < CHANNEL; v++)
        vc_ready_q[v] <= (state_q[v] == VC_IDLE) && empty[v] && !push[v];
    end
  end

`ifdef NOC_VC_BUF_ERR_CHECK_EN
  logic [CHANNEL-1:0] err_q;
  logic [CHANNEL-1:0] err_set;

  // Error sources: header inside a packet, non-header outside a packet,
  // or a contended shared lane.
  always_comb begin
    err_set = '0;
    for (int v = 0; v < CHANNEL; v++) begin
      if (push[v] && ((state_q[v] == VC_IDLE) != hdr_sel[v])) err_set[v] = 1'b1;
      if (multi_valid && link.in_valid[v])                    err_set[v] = 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | err_set;
  end

  assign err = err_q;

  // Flag a sender that ignores in_ready.
  always @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < CHANNEL; v++)
        assert (!(link.in_valid[v] && full[v]))
          else $warning("push attempted on full VC %0d", v);
    end
  end
`else
  assign err = '0;
`endif

endmodule
